// File: rtl/lcd_char_sequencer.sv
// ============================================================================
// lcd_char_sequencer
//
// Writes characters to an HD44780-compatible character LCD over its 4-bit bus
// once power-on initialisation is complete. For every screen position it
// sends a Set-DDRAM-Address command {1, addr}, then the character supplied by
// the message memory. After each character it pulses the advance strobes for
// one cycle so the address controller steps both the screen address and the
// memory address.
//
// Every byte goes out as two nibbles (high first). Each nibble is
// setup / enable / hold, timed by a single 16-bit down-counter. A short gap
// follows the high nibble. A long wait follows the low nibble to cover the
// LCD's execution time.
//
// Ports
//   clk                 in   system clock (50 MHz)
//   reset               in   asynchronous, active-high reset
//   start               in   high while initialisation runs; block idles
//   addr[6:0]           in   current screen address (0-15 or 64-79)
//   char_data[7:0]      in   character at the current memory address
//   lcd_data[3:0]       out  LCD DB[7:4]
//   lcd_e               out  LCD enable
//   lcd_rs              out  0 = command, 1 = data
//   lcd_rw              out  tied 0 (write only)
//   change_addr         out  one-cycle strobe: advance screen address
//   change_memory_addr  out  one-cycle strobe: advance memory address
//   busy                out  high whenever the sequencer is not in IDLE
//
// All outputs are registers. Their next values are decoded from the next
// state, so they change on the same edge as the state. The LCD pins are
// therefore glitch-free. They also drop to 0 as soon as reset is asserted.
// ============================================================================
module lcd_char_sequencer #(
    parameter int T_SETUP      = 2,     // cycles data/RS valid before E rises
    parameter int T_ENABLE     = 12,    // cycles E is high
    parameter int T_HOLD       = 1,     // cycles data/RS held after E falls
    parameter int T_NIBBLE_GAP = 50,    // idle cycles between the two nibbles
    parameter int T_BYTE_WAIT  = 2000   // idle cycles after the low nibble
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] char_data,
    output logic [3:0] lcd_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       change_addr,
    output logic       change_memory_addr,
    output logic       busy
);

    // Counter load values. A phase of N cycles loads N-1 and ends on the
    // cycle the counter reads 0. Every timing parameter must therefore be
    // at least 1.
    localparam logic [15:0] LD_SETUP  = 16'(T_SETUP - 1);
    localparam logic [15:0] LD_ENABLE = 16'(T_ENABLE - 1);
    localparam logic [15:0] LD_HOLD   = 16'(T_HOLD - 1);
    localparam logic [15:0] LD_GAP    = 16'(T_NIBBLE_GAP - 1);
    localparam logic [15:0] LD_WAIT   = 16'(T_BYTE_WAIT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD_HI,
        S_CMD_GAP,
        S_CMD_LO,
        S_CMD_WAIT,
        S_DAT_HI,
        S_DAT_GAP,
        S_DAT_LO,
        S_DAT_WAIT,
        S_ADVANCE
    } state_t;

    // Sub-phase used inside the four nibble states.
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_ENABLE,
        PH_HOLD
    } phase_t;

    state_t      state_reg,  state_next;
    phase_t      phase_reg,  phase_next;
    logic [15:0] cnt_reg,    cnt_next;
    logic [7:0]  cmd_reg,    cmd_next;
    logic [7:0]  chr_reg,    chr_next;

    logic [3:0]  lcd_data_reg, lcd_data_next;
    logic        lcd_e_reg,    lcd_e_next;
    logic        lcd_rs_reg,   lcd_rs_next;
    logic        change_reg,   change_next;
    logic        busy_reg,     busy_next;

    logic        cnt_done;
    logic        nibble_next;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            phase_reg    <= PH_SETUP;
            cnt_reg      <= 16'd0;
            cmd_reg      <= 8'd0;
            chr_reg      <= 8'd0;
            lcd_data_reg <= 4'd0;
            lcd_e_reg    <= 1'b0;
            lcd_rs_reg   <= 1'b0;
            change_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            cnt_reg      <= cnt_next;
            cmd_reg      <= cmd_next;
            chr_reg      <= chr_next;
            lcd_data_reg <= lcd_data_next;
            lcd_e_reg    <= lcd_e_next;
            lcd_rs_reg   <= lcd_rs_next;
            change_reg   <= change_next;
            busy_reg     <= busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and output decode
    // ------------------------------------------------------------------
    always_comb begin
        cnt_done   = (cnt_reg == 16'd0);
        state_next = state_reg;
        phase_next = phase_reg;
        cnt_next   = cnt_done ? 16'd0 : (cnt_reg - 16'd1);
        cmd_next   = cmd_reg;
        chr_next   = chr_reg;

        case (state_reg)
            S_IDLE: begin
                if (!start) begin
                    // Set-DDRAM-Address command for the current position.
                    cmd_next   = {1'b1, addr};
                    state_next = S_CMD_HI;
                    phase_next = PH_SETUP;
                    cnt_next   = LD_SETUP;
                end
            end

            S_CMD_HI, S_CMD_LO, S_DAT_HI, S_DAT_LO: begin
                if (cnt_done) begin
                    case (phase_reg)
                        PH_SETUP: begin
                            phase_next = PH_ENABLE;
                            cnt_next   = LD_ENABLE;
                        end
                        PH_ENABLE: begin
                            phase_next = PH_HOLD;
                            cnt_next   = LD_HOLD;
                        end
                        default: begin
                            // End of hold. The high nibble is followed by
                            // the short gap. The low nibble is followed by
                            // the long execution wait.
                            phase_next = PH_SETUP;
                            case (state_reg)
                                S_CMD_HI: begin
                                    state_next = S_CMD_GAP;
                                    cnt_next   = LD_GAP;
                                end
                                S_CMD_LO: begin
                                    state_next = S_CMD_WAIT;
                                    cnt_next   = LD_WAIT;
                                end
                                S_DAT_HI: begin
                                    state_next = S_DAT_GAP;
                                    cnt_next   = LD_GAP;
                                end
                                default: begin
                                    state_next = S_DAT_WAIT;
                                    cnt_next   = LD_WAIT;
                                end
                            endcase
                        end
                    endcase
                end
            end

            S_CMD_GAP: begin
                if (cnt_done) begin
                    state_next = S_CMD_LO;
                    phase_next = PH_SETUP;
                    cnt_next   = LD_SETUP;
                end
            end

            S_CMD_WAIT: begin
                if (cnt_done) begin
                    // The memory has had the whole command byte to settle,
                    // so the character is sampled exactly once, here.
                    chr_next   = char_data;
                    state_next = S_DAT_HI;
                    phase_next = PH_SETUP;
                    cnt_next   = LD_SETUP;
                end
            end

            S_DAT_GAP: begin
                if (cnt_done) begin
                    state_next = S_DAT_LO;
                    phase_next = PH_SETUP;
                    cnt_next   = LD_SETUP;
                end
            end

            S_DAT_WAIT: begin
                if (cnt_done) begin
                    state_next = S_ADVANCE;
                    cnt_next   = 16'd0;
                end
            end

            S_ADVANCE: begin
                // Always return through IDLE. That is where start is
                // checked and the next command is latched from the
                // freshly stepped address.
                state_next = S_IDLE;
                cnt_next   = 16'd0;
            end

            default: begin
                state_next = S_IDLE;
                phase_next = PH_SETUP;
                cnt_next   = 16'd0;
            end
        endcase

        // Bus outputs follow the next state. Outside the nibble states the
        // data and RS lines keep their last value.
        lcd_data_next = lcd_data_reg;
        lcd_rs_next   = lcd_rs_reg;
        case (state_next)
            S_CMD_HI: begin
                lcd_data_next = cmd_next[7:4];
                lcd_rs_next   = 1'b0;
            end
            S_CMD_LO: begin
                lcd_data_next = cmd_next[3:0];
                lcd_rs_next   = 1'b0;
            end
            S_DAT_HI: begin
                lcd_data_next = chr_next[7:4];
                lcd_rs_next   = 1'b1;
            end
            S_DAT_LO: begin
                lcd_data_next = chr_next[3:0];
                lcd_rs_next   = 1'b1;
            end
            default: begin
            end
        endcase

        nibble_next = (state_next == S_CMD_HI) || (state_next == S_CMD_LO) ||
                      (state_next == S_DAT_HI) || (state_next == S_DAT_LO);
        lcd_e_next  = nibble_next && (phase_next == PH_ENABLE);
        change_next = (state_next == S_ADVANCE);
        busy_next   = (state_next != S_IDLE);
    end

    assign lcd_data           = lcd_data_reg;
    assign lcd_e              = lcd_e_reg;
    assign lcd_rs             = lcd_rs_reg;
    assign lcd_rw             = 1'b0;
    assign change_addr        = change_reg;
    assign change_memory_addr = change_reg;
    assign busy               = busy_reg;

endmodule

// File: tb/tb_lcd_char_sequencer.sv
// ============================================================================
// tb_lcd_char_sequencer
//
// Directed test of lcd_char_sequencer with its default timing. A negedge
// monitor records every E pulse: its {rs,data} value, the rise cycle, the
// width, and whether data/RS stayed stable from setup through hold. It also
// records the cycle of each advance strobe. A small controller model steps
// the screen address and the message index on change_addr. The directed
// steps compare the recorded activity against hand-computed nibble values
// and cycle offsets.
// ============================================================================
module tb_lcd_char_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] addr;
    logic [7:0] char_data;
    logic [3:0] lcd_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       change_addr;
    logic       change_memory_addr;
    logic       busy;

    lcd_char_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .addr               (addr),
        .char_data          (char_data),
        .lcd_data           (lcd_data),
        .lcd_e              (lcd_e),
        .lcd_rs             (lcd_rs),
        .lcd_rw             (lcd_rw),
        .change_addr        (change_addr),
        .change_memory_addr (change_memory_addr),
        .busy               (busy)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Cycle counter and count of advance strobes seen.
    int cyc       = 0;
    int adv_count = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (change_addr) adv_count <= adv_count + 1;
    end

    // Address controller / message memory model.
    logic [6:0] base_addr = 7'd0;
    int         base_idx  = 0;
    int         msg_base  = 0;
    logic [7:0] msg [8];
    logic [2:0] msg_idx;

    function automatic logic [6:0] addr_after(input logic [6:0] a, input int n);
        logic [6:0] r;
        r = a;
        for (int i = 0; i < n && i < 64; i++)
            r = (r == 7'd15) ? 7'd64 : (r == 7'd79) ? 7'd0 : r + 7'd1;
        return r;
    endfunction

    assign addr      = addr_after(base_addr, adv_count - base_idx);
    assign msg_idx   = 3'(msg_base + adv_count - base_idx);
    assign char_data = msg[msg_idx];

    // Bus monitor.
    typedef struct {
        logic [4:0] val;
        int         rise;
        int         width;
        logic       ok;
    } pulse_t;

    pulse_t     pulses [$];
    int         strobes [$];
    int         coinc_bad = 0;
    int         rw_bad    = 0;
    logic       e_prev    = 1'b0;
    logic [4:0] h1 = 5'd0, h2 = 5'd0, p_val = 5'd0;
    int         p_rise = 0;
    logic       p_ok   = 1'b0;
    logic [4:0] cur;
    assign cur = {lcd_rs, lcd_data};

    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            p_val  <= cur;
            p_rise <= cyc;
            p_ok   <= (h1 == cur) && (h2 == cur);
        end else if (lcd_e && e_prev) begin
            p_ok <= p_ok && (cur == p_val);
        end else if (!lcd_e && e_prev) begin
            pulses.push_back(pulse_t'{p_val, p_rise, cyc - p_rise, p_ok && (cur == p_val)});
        end
        if (change_addr) strobes.push_back(cyc);
        if (change_addr !== change_memory_addr) coinc_bad <= coinc_bad + 1;
        if (lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
        e_prev <= lcd_e;
        h1     <= cur;
        h2     <= h1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Checks the four nibbles of one character that started at cycle s0.
    task automatic check_char(input string tag, input int pidx, input int s0,
                              input logic [4:0] e0, input logic [4:0] e1,
                              input logic [4:0] e2, input logic [4:0] e3);
        int         offs [4];
        logic [4:0] ev   [4];
        offs = '{2, 67, 2082, 2147};
        ev   = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_p%0d_present", tag, k), 32'(pulses.size() > pidx + k), 32'd1);
            if (pulses.size() > pidx + k) begin
                check($sformatf("%s_p%0d_val", tag, k), 32'(pulses[pidx+k].val), 32'(ev[k]));
                check($sformatf("%s_p%0d_rise", tag, k), pulses[pidx+k].rise, s0 + offs[k]);
                check($sformatf("%s_p%0d_width", tag, k), pulses[pidx+k].width, 32'd12);
                check($sformatf("%s_p%0d_stable", tag, k), 32'(pulses[pidx+k].ok), 32'd1);
            end
        end
    endtask

    task automatic check_strobe(input string tag, input int sidx, input int exp_cyc);
        check($sformatf("%s_present", tag), 32'(strobes.size() > sidx), 32'd1);
        if (strobes.size() > sidx)
            check($sformatf("%s_cycle", tag), strobes[sidx], exp_cyc);
    endtask

    int s;
    int pb;
    int sb;

    initial begin
        msg = '{8'h48, 8'h4C, 8'h43, 8'h44, 8'h21, 8'h5A, 8'h7E, 8'h30};
        reset = 1'b1;
        start = 1'b1;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_data", lcd_data, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_busy", busy, 0);
        check("rst_change", change_addr, 0);
        reset = 1'b0;
        repeat (1000) @(negedge clk);
        check("idle_pulses", pulses.size(), 0);
        check("idle_strobes", strobes.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_lcd_e", lcd_e, 0);
        check("idle_lcd_data", lcd_data, 0);

        // ---- single character: addr 0, 'H' ----
        pb = pulses.size(); sb = strobes.size();
        base_addr = 7'd0; base_idx = adv_count; msg_base = 0;
        start = 1'b0; s = cyc + 1;
        @(negedge clk); start = 1'b1;
        wait_until(s + 1000);
        check("single_busy_mid", busy, 1);
        wait_until(s + 4170);
        check_char("single", pb, s, 5'h08, 5'h00, 5'h14, 5'h18);
        check("single_strobe_n", strobes.size() - sb, 1);
        check_strobe("single_strobe", sb, s + 4160);
        check("single_busy_end", busy, 0);
        $display("txn single addr=0x00 chr=0x48 pulses=%0d", pulses.size() - pb);

        // ---- reset during ENABLE of DAT_HI ----
        base_addr = 7'd5; base_idx = adv_count; msg_base = 5;
        start = 1'b0; s = cyc + 1;
        wait_until(s + 2085);
        check("pre_rst_lcd_e", lcd_e, 1);
        check("pre_rst_lcd_rs", lcd_rs, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_lcd_e", lcd_e, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_lcd_rs", lcd_rs, 0);
        check("mid_rst_lcd_data", lcd_data, 0);
        repeat (3) @(negedge clk);
        pb = pulses.size(); sb = strobes.size();
        reset = 1'b0; s = cyc + 1;
        @(negedge clk); start = 1'b1;
        wait_until(s + 4170);
        check_char("after_rst", pb, s, 5'h08, 5'h05, 5'h15, 5'h1A);
        check_strobe("after_rst_strobe", sb, s + 4160);
        $display("txn reset_recovery addr=0x05 chr=0x5A pulses=%0d", pulses.size() - pb);

        // ---- continuous run across the line wrap: addr 14,15,64,65 ----
        pb = pulses.size(); sb = strobes.size();
        base_addr = 7'd14; base_idx = adv_count; msg_base = 1;
        start = 1'b0; s = cyc + 1;
        wait_until(s + 3 * 4162 + 100);
        start = 1'b1;
        wait_until(s + 4 * 4162 + 10);
        check_char("run_c0", pb + 0,  s,            5'h08, 5'h0E, 5'h14, 5'h1C);
        check_char("run_c1", pb + 4,  s + 4162,     5'h08, 5'h0F, 5'h14, 5'h13);
        check_char("run_c2", pb + 8,  s + 2 * 4162, 5'h0C, 5'h00, 5'h14, 5'h14);
        check_char("run_c3", pb + 12, s + 3 * 4162, 5'h0C, 5'h01, 5'h12, 5'h11);
        check("run_strobe_n", strobes.size() - sb, 4);
        for (int c = 0; c < 4; c++)
            check_strobe($sformatf("run_strobe%0d", c), sb + c, s + 4160 + 4162 * c);
        $display("txn run chars=4 strobes=%0d", strobes.size() - sb);

        // ---- last screen position: addr 79, '~' ----
        pb = pulses.size(); sb = strobes.size();
        base_addr = 7'd79; base_idx = adv_count; msg_base = 6;
        start = 1'b0; s = cyc + 1;
        @(negedge clk); start = 1'b1;
        wait_until(s + 4170);
        check_char("addr79", pb, s, 5'h0C, 5'h0F, 5'h17, 5'h1E);
        check_strobe("addr79_strobe", sb, s + 4160);
        $display("txn addr79 addr=0x4F chr=0x7E pulses=%0d", pulses.size() - pb);

        check("strobe_coincidence_errors", coinc_bad, 0);
        check("lcd_rw_nonzero_cycles", rw_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_char_sequencer.md
# lcd_char_sequencer

Writes characters to the HD44780-compatible character LCD over its 4-bit interface once the power-on initialisation phase has finished. For each screen position it sends a Set-DDRAM-Address command built from the current screen address, then writes the character supplied by the message memory. After each character it pulses the advance strobes so the address controller steps to the next screen position and the next memory location. It owns all LCD bus timing: setup, enable pulse width, hold, inter-nibble gap and post-byte execution wait.

## Interface
- T_SETUP, 2: cycles with RS/data valid and E low before E rises.
- T_ENABLE, 12: cycles E is held high.
- T_HOLD, 1: cycles RS/data are held after E falls.
- T_NIBBLE_GAP, 50: idle cycles between the high and low nibble of one byte.
- T_BYTE_WAIT, 2000: idle cycles after the low nibble, covering the LCD execution time.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- start  in  1  high while the initialisation phase runs; this block stays idle while it is high
- addr  in  7  current screen address (0–15 or 64–79)
- char_data  in  8  character read from memory at the current memory address
- lcd_data  out  4  LCD DB[7:4]
- lcd_e  out  1  LCD enable
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  constant 0 (write only)
- change_addr  out  1  one-cycle strobe: advance the screen address
- change_memory_addr  out  1  one-cycle strobe: advance the memory address
- busy  out  1  high in every state except IDLE

## Operation
- Reset values: all outputs 0; state IDLE; internal counter 0.
- States: IDLE, CMD_HI, CMD_GAP, CMD_LO, CMD_WAIT, DAT_HI, DAT_GAP, DAT_LO, DAT_WAIT, ADVANCE.
- IDLE:
  - If start = 0, latch cmd_reg = {1'b1, addr} and go to CMD_HI.
  - Otherwise stay in IDLE.
- Nibble states (CMD_HI, CMD_LO, DAT_HI, DAT_LO) each run three sub-phases driven by one down-counter:
  - SETUP: T_SETUP cycles, E = 0.
  - ENABLE: T_ENABLE cycles, E = 1.
  - HOLD: T_HOLD cycles, E = 0.
  - lcd_data and lcd_rs are stable for the whole nibble state.
- Nibble values:
  - CMD_HI drives cmd_reg[7:4], RS = 0.
  - CMD_LO drives cmd_reg[3:0], RS = 0.
  - DAT_HI drives chr_reg[7:4], RS = 1.
  - DAT_LO drives chr_reg[3:0], RS = 1.
- CMD_GAP and DAT_GAP: T_NIBBLE_GAP cycles; E = 0; lcd_data and RS keep their last value.
- CMD_WAIT: T_BYTE_WAIT cycles, then latch chr_reg = char_data and go to DAT_HI.
- DAT_WAIT: T_BYTE_WAIT cycles, then go to ADVANCE.
- ADVANCE: exactly one cycle with change_addr = change_memory_addr = 1.
  - If start = 0, latch the new cmd_reg on the next cycle (from IDLE) and continue.
  - Otherwise go to IDLE.
- start is sampled only in IDLE. A start rise mid-character is honoured only after that character's ADVANCE completes.
- Counter: 16 bits, loaded with (phase length − 1), counts down to 0, and the phase ends on the 0 cycle. Every parameter must be ≥ 1.
- Reset mid-operation: all outputs return to 0 asynchronously, including E if it was high. Sequencing restarts from IDLE with a fresh command; no partial byte is resumed.

## Timing
- Each nibble lasts T_SETUP + T_ENABLE + T_HOLD = 15 cycles.
- E rises on the (T_SETUP+1)th cycle of the nibble and stays high exactly T_ENABLE cycles.
- Per byte: 15 + 50 + 15 + 2000 = 2080 cycles. Per character: 2 × 2080 + 1 (ADVANCE) + 1 (IDLE) = 4162 cycles.
- The first lcd_e rise occurs T_SETUP + 1 cycles after the first clock edge that sees start = 0.
- change_addr and change_memory_addr are coincident single-cycle pulses and never occur outside ADVANCE.
- char_data is sampled once per character, at the end of CMD_WAIT. This is at least 2080 cycles after the previous ADVANCE, which covers the memory read latency.

## Test plan
- Reset behaviour: hold reset, then release with start = 1 for 1000 cycles → all outputs 0, busy = 0, no activity on lcd_e.
- Single character: addr = 0, char_data = 0x48, start falls → nibbles 0x8, 0x0 with RS = 0, then 0x4, 0x8 with RS = 1. Exactly one change strobe pulse, at cycle 4161 after the start fall. lcd_rw is always 0.
- Line wrap: addr = 15 gives command nibbles 0x8, 0xF; addr = 64 gives 0xC, 0x0; addr = 79 gives 0xC, 0xF.
- Bus timing: measure every E pulse → high for exactly 12 cycles, data/RS stable from 2 cycles before E rises to 1 cycle after E falls, 50 cycles between nibbles, 2000 idle cycles after each low nibble.
- Reset during ENABLE of DAT_HI: lcd_e goes low in the same cycle. After release, the next transfer starts with a full command byte (RS = 0).
- Continuous run: start held at 0 for 32 characters → 32 strobe pairs spaced exactly 4162 cycles apart, with addresses supplied by the stepping controller.
